serial_add_sequencer: RTL



---
 rtl/serial_add_sequencer_if.sv | 28 ++
 rtl/serial_add_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer_if.sv
// Request/response bundle between ALU issue logic, the serial add sequencer and the result bus.
interface serial_add_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  op_sub;
    logic                  c_in;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  carry_out;
    logic                  overflow;
    logic                  zero;
    logic                  busy;

    modport master (
        output req_valid, op_a, op_b, op_sub, c_in, rsp_ready,
        input  req_ready, rsp_valid, result, carry_out, overflow, zero, busy
    );

    modport slave (
        input  req_valid, op_a, op_b, op_sub, c_in, rsp_ready,
        output req_ready, rsp_valid, result, carry_out, overflow, zero, busy
    );
endinterface

// File: rtl/serial_add_sequencer.sv
// Byte-serial DATA_WIDTH add/subtract over one shared 8-bit CLA slice, LSB first.
// Optional subtract support is enabled by defining SERIAL_ADD_SUB_EN.

// 8-bit carry-lookahead slice; only group generate/propagate leave the slice.
module cla8_slice (
    input  logic [7:0] input_a,
    input  logic [7:0] input_b,
    input  logic       c_in,
    output logic [7:0] sum,
    output logic       bigG,
    output logic       bigP
);
    logic [7:0] g;
    logic [7:0] p;
    logic       c;
    logic       gg;

    assign g    = input_a & input_b;
    assign p    = input_a ^ input_b;
    assign bigP = &p;
    assign bigG = gg;

    always_comb begin
        sum = '0;
        c   = c_in;
        gg  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = p[i] ^ c;
            c      = g[i] | (p[i] & c);
            gg     = g[i] | (p[i] & gg);
        end
    end
endmodule

module serial_add_sequencer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    serial_add_sequencer_if.slave  bus
);
    localparam int unsigned N     = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [N-1:0][7:0] a_reg;
    logic [N-1:0][7:0] b_reg;
    logic [N-1:0][7:0] result_reg;
    logic [N-1:0][7:0] result_nxt_c;
    logic [CNT_W-1:0]  k_q;
    logic              carry_reg;
    logic              overflow_reg;
    logic              zero_reg;

    logic [7:0]            slice_sum;
    logic                  slice_g;
    logic                  slice_p;
    logic                  accept_c;
    logic                  last_c;
    logic [DATA_WIDTH-1:0] b_eff_c;
    logic                  carry_seed_c;
    logic                  req_ready_c;
    logic                  rsp_valid_c;
    logic                  busy_c;

    assign accept_c = (state_q == IDLE) && bus.req_valid;
    assign last_c   = (k_q == LAST_K);

`ifdef SERIAL_ADD_SUB_EN
    // Subtract as A + ~B + 1.
    assign b_eff_c      = bus.op_sub ? ~bus.op_b : bus.op_b;
    assign carry_seed_c = bus.op_sub ? 1'b1 : bus.c_in;
`else
    logic unused_op_sub;
    assign unused_op_sub = bus.op_sub;
    assign b_eff_c       = bus.op_b;
    assign carry_seed_c  = bus.c_in;
`endif

    cla8_slice u_slice (
        .input_a (a_reg[k_q]),
        .input_b (b_reg[k_q]),
        .c_in    (carry_reg),
        .sum     (slice_sum),
        .bigG    (slice_g),
        .bigP    (slice_p)
    );

    always_comb begin
        result_nxt_c      = result_reg;
        result_nxt_c[k_q] = slice_sum;
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = RUN;
            RUN:     if (last_c)        state_d = DONE;
            DONE:    if (bus.rsp_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Handshake/status outputs decoded from state only
    always_comb begin
        req_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state_q)
            IDLE:    req_ready_c = 1'b1;
            RUN:     busy_c      = 1'b1;
            DONE: begin
                rsp_valid_c = 1'b1;
                busy_c      = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand capture and byte-serial datapath; carry rebuilt from group G/P
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            result_reg   <= '0;
            k_q          <= '0;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        a_reg        <= bus.op_a;
                        b_reg        <= b_eff_c;
                        carry_reg    <= carry_seed_c;
                        k_q          <= '0;
                        result_reg   <= '0;
                        overflow_reg <= 1'b0;
                        zero_reg     <= 1'b0;
                    end
                end
                RUN: begin
                    result_reg <= result_nxt_c;
                    carry_reg  <= slice_g | (slice_p & carry_reg);
                    if (last_c) begin
                        overflow_reg <= (a_reg[N-1][7] == b_reg[N-1][7]) &&
                                        (slice_sum[7] != a_reg[N-1][7]);
                        zero_reg     <= ~|result_nxt_c;
                    end else begin
                        k_q <= k_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.busy      = busy_c;
    assign bus.result    = result_reg;
    assign bus.carry_out = carry_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.zero      = zero_reg;
endmodule
